// File: rtl/apd_hv_comp_pwl_pkg.sv
// Shared types for the APD HV compensator: one-hot FSM states, zone codes and
// the width helper for the signed target/clamp datapath.
package apd_hv_pkg;

  typedef enum logic [7:0] {
    ST_IDLE    = 8'b0000_0001,
    ST_CAPTURE = 8'b0000_0010,
    ST_MUL1    = 8'b0000_0100,
    ST_MUL2    = 8'b0000_1000,
    ST_SUM     = 8'b0001_0000,
    ST_CLAMP   = 8'b0010_0000,
    ST_SLEW    = 8'b0100_0000,
    ST_OUT     = 8'b1000_0000
  } state_t;

  localparam logic [1:0] ZONE_LINEAR = 2'b00;
  localparam logic [1:0] ZONE_HOT    = 2'b01;
  localparam logic [1:0] ZONE_COLD   = 2'b10;

  // Signed width that holds hv_base +/- the full-width correction plus headroom.
  function automatic int calc_w(input int hv_w, input int coe_w, input int temp_w);
    int w;
    w = coe_w + temp_w + 3;
    if (hv_w > w) begin
      w = hv_w;
    end else begin
      w = w;
    end
    return w + 2;
  endfunction

endpackage

// File: rtl/apd_hv_comp_pwl_if.sv
// Temperature-in / DAC-out bundle of the APD HV compensator.
interface apd_hv_comp_pwl_if #(
  parameter int TEMP_W = 8,
  parameter int COE_W  = 8,
  parameter int HV_W   = 12,
  parameter int DAC_W  = 10
);
  logic              i_temp_valid;
  logic [TEMP_W-1:0] i_temp_value;
  logic [TEMP_W-1:0] i_temp_base;
  logic [COE_W-1:0]  i_temp_coe;
  logic [HV_W-1:0]   i_hv_base;
  logic [HV_W-1:0]   i_max_step;
  logic              i_comp_en;
  logic              o_busy;
  logic              o_dac_start;
  logic [DAC_W-1:0]  o_dac_value;
  logic [HV_W-1:0]   o_hv_code;
  logic [1:0]        o_zone;
  logic              o_clamped;

  modport master (
    output i_temp_valid, i_temp_value, i_temp_base, i_temp_coe, i_hv_base, i_max_step, i_comp_en,
    input  o_busy, o_dac_start, o_dac_value, o_hv_code, o_zone, o_clamped
  );

  modport slave (
    input  i_temp_valid, i_temp_value, i_temp_base, i_temp_coe, i_hv_base, i_max_step, i_comp_en,
    output o_busy, o_dac_start, o_dac_value, o_hv_code, o_zone, o_clamped
  );
endinterface

// File: rtl/apd_hv_comp_pwl_mult.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle. Bit 0 is folded
// into the start cycle so done pulses exactly BW cycles after start.
module seq_mult_u #(
  parameter int AW = 9,
  parameter int BW = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    a,
  input  logic [BW-1:0]    b,
  output logic             done,
  output logic [AW+BW-1:0] product
);
  localparam int PW    = AW + BW;
  localparam int CNT_W = $clog2(BW + 1);

  logic [PW-1:0]    acc_r;
  logic [PW-1:0]    a_sh_r;
  logic [BW-1:0]    b_sh_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;

  // Load on start, then add one shifted partial product per cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_r  <= '0;
      a_sh_r <= '0;
      b_sh_r <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else if (start) begin
      acc_r  <= b[0] ? PW'(a) : '0;
      a_sh_r <= PW'(a) << 1;
      b_sh_r <= b >> 1;
      cnt_r  <= CNT_W'(BW - 1);
      done_r <= 1'b0;
    end else if (cnt_r != '0) begin
      if (b_sh_r[0]) begin
        acc_r <= acc_r + a_sh_r;
      end
      a_sh_r <= a_sh_r << 1;
      b_sh_r <= b_sh_r >> 1;
      cnt_r  <= cnt_r - CNT_W'(1);
      done_r <= (cnt_r == CNT_W'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done    = done_r;
  assign product = acc_r;
endmodule

// File: rtl/apd_hv_comp_pwl.sv
// APD HV temperature compensator: three-zone piecewise-linear correction around
// a runtime base point, clamp, slew limit and a single DAC update strobe.
module apd_hv_comp_pwl #(
  parameter int TEMP_W    = 8,
  parameter int COE_W     = 8,
  parameter int HV_W      = 12,
  parameter int DAC_W     = 10,
  parameter int HV_MIN    = 1150,
  parameter int HV_MAX    = 4000,
  parameter int HOT_KNEE  = 20,
  parameter int COLD_KNEE = 30
) (
  input logic               i_clk_50m,
  input logic               i_rst_n,
  apd_hv_comp_pwl_if.slave  bus
);
  import apd_hv_pkg::*;

  localparam int DW = TEMP_W + 1;
  localparam int AW = COE_W + 1;
  localparam int PW = AW + DW;
  localparam int CW = calc_w(HV_W, COE_W, TEMP_W);
  localparam logic signed [CW-1:0] HV_MIN_C = CW'(HV_MIN);
  localparam logic signed [CW-1:0] HV_MAX_C = CW'(HV_MAX);

  state_t state_r, next_s;

  logic [DW-1:0] delta_s, mag_s, knee_s, m1_s, m2_s;
  logic [AW-1:0] scoe_s, mul_a_s;
  logic [DW-1:0] mul_b_s;
  logic          neg_s, mul_start_s, mul_done_s;
  logic [1:0]    zone_s;
  logic [PW-1:0] mul_prod_s;
  logic [CW-1:0] corr_s;

  logic [HV_W-1:0]       hv_base_r, max_step_r, tgt_r, new_r, hv_code_r, slew_s;
  logic [AW-1:0]         scoe_r;
  logic [DW-1:0]         m2_r;
  logic [PW-1:0]         p1_r;
  logic signed [CW-1:0]  sum_r;
  logic [HV_W+1:0]       diff_s, adiff_s;
  logic [1:0]            zone_pend_r, zone_r;
  logic                  sub_r, clamp_pend_r, clamped_r, primed_r, busy_r, dac_start_r;

  // Split |temp - base| at the knee into the base-slope and scaled-slope segments.
  always_comb begin
    delta_s = {bus.i_temp_value[TEMP_W-1], bus.i_temp_value}
            - {bus.i_temp_base[TEMP_W-1], bus.i_temp_base};
    neg_s   = delta_s[DW-1];
    mag_s   = neg_s ? (~delta_s) + DW'(1) : delta_s;
    knee_s  = neg_s ? DW'(COLD_KNEE) : DW'(HOT_KNEE);
    scoe_s  = neg_s ? {2'b00, bus.i_temp_coe[COE_W-1:1]} : {bus.i_temp_coe, 1'b0};
    m1_s    = mag_s;
    m2_s    = '0;
    zone_s  = ZONE_LINEAR;
    if (!bus.i_comp_en) begin
      m1_s = '0;
    end else if (mag_s > knee_s) begin
      m1_s = knee_s;
      m2_s = mag_s - knee_s;
    end else begin
      m1_s = mag_s;
    end
    if (bus.i_comp_en && !neg_s && mag_s >= DW'(HOT_KNEE)) begin
      zone_s = ZONE_HOT;
    end else if (bus.i_comp_en && neg_s && mag_s >= DW'(COLD_KNEE)) begin
      zone_s = ZONE_COLD;
    end else begin
      zone_s = ZONE_LINEAR;
    end
  end

  // The first product starts straight from the inputs in CAPTURE; the second from the captured segment.
  always_comb begin
    mul_start_s = (state_r == ST_CAPTURE) || ((state_r == ST_MUL1) && mul_done_s);
    if (state_r == ST_CAPTURE) begin
      mul_a_s = {1'b0, bus.i_temp_coe};
      mul_b_s = m1_s;
    end else begin
      mul_a_s = scoe_r;
      mul_b_s = m2_r;
    end
    corr_s = CW'(p1_r) + CW'(mul_prod_s);
  end

  seq_mult_u #(.AW(AW), .BW(DW)) u_mult (
    .clk     (i_clk_50m),
    .rst_n   (i_rst_n),
    .start   (mul_start_s),
    .a       (mul_a_s),
    .b       (mul_b_s),
    .done    (mul_done_s),
    .product (mul_prod_s)
  );

  // Slew limit against the currently applied code once a first update has gone out.
  always_comb begin
    diff_s  = {2'b00, tgt_r} - {2'b00, hv_code_r};
    adiff_s = diff_s[HV_W+1] ? (~diff_s) + (HV_W+2)'(1) : diff_s;
    if (primed_r && (max_step_r != '0) && (adiff_s > {2'b00, max_step_r})) begin
      slew_s = diff_s[HV_W+1] ? hv_code_r - max_step_r : hv_code_r + max_step_r;
    end else begin
      slew_s = tgt_r;
    end
  end

  // FSM next state.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:    next_s = bus.i_temp_valid ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: next_s = ST_MUL1;
      ST_MUL1:    next_s = mul_done_s ? ST_MUL2 : ST_MUL1;
      ST_MUL2:    next_s = mul_done_s ? ST_SUM : ST_MUL2;
      ST_SUM:     next_s = ST_CLAMP;
      ST_CLAMP:   next_s = ST_SLEW;
      ST_SLEW:    next_s = ST_OUT;
      ST_OUT:     next_s = ST_IDLE;
      default:    next_s = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Datapath and registered outputs, stepped by the FSM.
  always_ff @(posedge i_clk_50m) begin
    if (!i_rst_n) begin
      hv_base_r <= '0; max_step_r <= '0; scoe_r <= '0; m2_r <= '0; sub_r <= 1'b0;
      zone_pend_r <= ZONE_LINEAR; p1_r <= '0; sum_r <= '0; tgt_r <= '0;
      clamp_pend_r <= 1'b0; new_r <= '0;
      hv_code_r <= HV_W'(HV_MIN); zone_r <= ZONE_LINEAR; clamped_r <= 1'b0;
      primed_r <= 1'b0; busy_r <= 1'b0; dac_start_r <= 1'b0;
    end else begin
      dac_start_r <= 1'b0;
      busy_r      <= (next_s != ST_IDLE) && (next_s != ST_OUT);
      case (state_r)
        ST_CAPTURE: begin
          hv_base_r   <= bus.i_hv_base;
          max_step_r  <= bus.i_max_step;
          scoe_r      <= scoe_s;
          m2_r        <= m2_s;
          sub_r       <= neg_s;
          zone_pend_r <= zone_s;
        end
        ST_MUL1: begin
          if (mul_done_s) p1_r <= mul_prod_s;
        end
        ST_SUM: sum_r <= sub_r ? CW'(hv_base_r) - corr_s : CW'(hv_base_r) + corr_s;
        ST_CLAMP: begin
          if (sum_r < HV_MIN_C) begin
            tgt_r <= HV_W'(HV_MIN); clamp_pend_r <= 1'b1;
          end else if (sum_r > HV_MAX_C) begin
            tgt_r <= HV_W'(HV_MAX); clamp_pend_r <= 1'b1;
          end else begin
            tgt_r <= HV_W'(sum_r);  clamp_pend_r <= 1'b0;
          end
        end
        ST_SLEW: new_r <= slew_s;
        ST_OUT: begin
          hv_code_r   <= new_r;
          zone_r      <= zone_pend_r;
          clamped_r   <= clamp_pend_r;
          primed_r    <= 1'b1;
          dac_start_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy      = busy_r;
  assign bus.o_dac_start = dac_start_r;
  assign bus.o_hv_code   = hv_code_r;
  assign bus.o_dac_value = hv_code_r[HV_W-1 -: DAC_W];
  assign bus.o_zone      = zone_r;
  assign bus.o_clamped   = clamped_r;
endmodule

// File: tb/tb_apd_hv_comp_pwl.sv
// Randomised bench for apd_hv_comp_pwl against an integer piecewise-linear model.
module tb_apd_hv_comp_pwl;
  localparam int TEMP_W = 8, COE_W = 8, HV_W = 12, DAC_W = 10;
  localparam int HV_MIN = 1150, HV_MAX = 4000, LATENCY = 2 * TEMP_W + 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_hv = HV_MIN;
  bit   m_primed = 1'b0;

  apd_hv_comp_pwl_if #(.TEMP_W(TEMP_W), .COE_W(COE_W), .HV_W(HV_W), .DAC_W(DAC_W)) bus ();

  apd_hv_comp_pwl #(.TEMP_W(TEMP_W), .COE_W(COE_W), .HV_W(HV_W), .DAC_W(DAC_W)) dut (
    .i_clk_50m (clk),
    .i_rst_n   (rst_n),
    .bus       (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: zone/correction straight from the piecewise rules, then clamp and slew.
  task automatic model(input int temp, base, coe, hvb, step, input bit en,
                       output int hv, output int zone, output int clamped);
    int delta, mag, corr, t;
    delta = temp - base;
    mag   = (delta < 0) ? -delta : delta;
    corr  = 0;
    zone  = 0;
    if (en && delta >= 0) begin
      corr = coe * ((mag < 20) ? mag : 20) + 2 * coe * ((mag > 20) ? mag - 20 : 0);
      zone = (delta >= 20) ? 1 : 0;
    end else if (en) begin
      corr = coe * ((mag < 30) ? mag : 30) + (coe / 2) * ((mag > 30) ? mag - 30 : 0);
      zone = (mag >= 30) ? 2 : 0;
    end
    t = (delta >= 0) ? hvb + corr : hvb - corr;
    clamped = (t < HV_MIN || t > HV_MAX) ? 1 : 0;
    if (t < HV_MIN) t = HV_MIN;
    if (t > HV_MAX) t = HV_MAX;
    if (m_primed && step != 0 && (t - m_hv > step || m_hv - t > step))
      m_hv = (t > m_hv) ? m_hv + step : m_hv - step;
    else
      m_hv = t;
    m_primed = 1'b1;
    hv = m_hv;
  endtask

  task automatic drive(input int temp, base, coe, hvb, step, input bit en);
    bus.i_temp_value = TEMP_W'(temp);
    bus.i_temp_base  = TEMP_W'(base);
    bus.i_temp_coe   = COE_W'(coe);
    bus.i_hv_base    = HV_W'(hvb);
    bus.i_max_step   = HV_W'(step);
    bus.i_comp_en    = en;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hv"}, int'(bus.o_hv_code), HV_MIN);
    check({tag, "_dac"}, int'(bus.o_dac_value), HV_MIN >> (HV_W - DAC_W));
    check({tag, "_busy"}, int'(bus.o_busy), 0);
    check({tag, "_strobe"}, int'(bus.o_dac_start), 0);
    check({tag, "_zone"}, int'(bus.o_zone), 0);
    check({tag, "_clamp"}, int'(bus.o_clamped), 0);
  endtask

  // One update; inputs are scrambled and extra valids (incl. cycle 5) injected while busy.
  task automatic run_update(input string tag, input int temp, base, coe, hvb, step, input bit en);
    int e_hv, e_zone, e_cl, first_k, n_strobe, o_hv, o_dac, o_zone, o_cl;
    model(temp, base, coe, hvb, step, en, e_hv, e_zone, e_cl);
    @(posedge clk); #1;
    drive(temp, base, coe, hvb, step, en);
    bus.i_temp_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_temp_valid = 1'b0;
    first_k = -1; n_strobe = 0; o_hv = -1; o_dac = -1; o_zone = -1; o_cl = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.o_dac_start) begin
        n_strobe++;
        if (first_k < 0) begin
          first_k = k; o_hv = int'(bus.o_hv_code); o_dac = int'(bus.o_dac_value);
          o_zone = int'(bus.o_zone); o_cl = int'(bus.o_clamped);
        end
      end
      if (k == 1)  check({tag, "_busy_cap"}, int'(bus.o_busy), 1);
      if (k == LATENCY - 2) check({tag, "_busy_slew"}, int'(bus.o_busy), 1);
      if (k == LATENCY - 1) check({tag, "_busy_out"}, int'(bus.o_busy), 0);
      if (k <= 20) begin
        drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 4095), $urandom_range(0, 4095), 1'($urandom_range(0, 1)));
        bus.i_temp_valid = (k == 4) || ($urandom_range(0, 3) == 0);
      end else begin
        bus.i_temp_valid = 1'b0;
      end
    end
    check({tag, "_strobe_cyc"}, first_k, LATENCY);
    check({tag, "_strobe_cnt"}, n_strobe, 1);
    check({tag, "_hv"}, o_hv, e_hv);
    check({tag, "_dac"}, o_dac, e_hv >> (HV_W - DAC_W));
    check({tag, "_zone"}, o_zone, e_zone);
    check({tag, "_clamp"}, o_cl, e_cl);
  endtask

  // Start an update and reset it at cycle 6: no strobe may follow.
  task automatic abort_update(input string tag);
    int n_strobe;
    @(posedge clk); #1;
    drive(55, 25, 10, 2000, 0, 1'b1);
    bus.i_temp_valid = 1'b1;
    @(posedge clk); #1;
    bus.i_temp_valid = 1'b0;
    n_strobe = 0;
    for (int k = 1; k <= 35; k++) begin
      @(posedge clk); #1;
      if (bus.o_dac_start) n_strobe++;
      if (k == 5) rst_n = 1'b0;
      if (k == 7) rst_n = 1'b1;
    end
    check({tag, "_no_strobe"}, n_strobe, 0);
    check_idle(tag);
    m_hv = HV_MIN;
    m_primed = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 1'b0);
    bus.i_temp_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    rst_n = 1'b1;

    run_update("t1_lin", 35, 25, 10, 2000, 0, 1'b1);
    run_update("t5_slew1", 55, 25, 10, 2000, 50, 1'b1);
    run_update("t5_slew2", 55, 25, 10, 2000, 50, 1'b1);
    run_update("t5_bypass", 55, 25, 10, 2000, 0, 1'b0);
    run_update("t2_hot", 55, 25, 10, 2000, 0, 1'b1);
    run_update("t3_cold", -15, 25, 10, 2000, 0, 1'b1);
    run_update("t4_clamp_hi", 55, 25, 10, 3900, 0, 1'b1);
    run_update("t4_clamp_lo", -15, 25, 10, 1200, 0, 1'b1);
    run_update("knee_hot", 45, 25, 7, 2000, 0, 1'b1);
    run_update("knee_cold", -5, 25, 7, 2000, 0, 1'b1);
    abort_update("t6_abort");
    run_update("t6_unslewed", 35, 25, 10, 2000, 50, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_update("rand", int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 $urandom_range(0, 255), $urandom_range(0, 4095),
                 ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 600),
                 ($urandom_range(0, 4) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/apd_hv_comp_pwl.md
Name: apd_hv_comp_pwl

Overview:
Parametrised APD high-voltage temperature compensator and the successor to the fixed-width APD bias block. It takes a signed device temperature with a valid strobe, applies a three-zone piecewise-linear correction around a runtime base point, clamps the result and slew-limits it. It then issues one DAC update strobe. It sits between the temperature-conversion path and the APD HV DAC driver, and uses a shared sequential shift-add multiplier in place of vendor multiplier IP.

Parameters:
TEMP_W, 8, signed temperature width (°C, integer)
COE_W, 8, unsigned coefficient width (HV codes per °C)
HV_W, 12, internal HV code width
DAC_W, 10, DAC code width; o_dac_value = o_hv_code[HV_W-1 -: DAC_W]
HV_MIN, 1150, lower clamp and reset HV code
HV_MAX, 4000, upper clamp
HOT_KNEE, 20, °C above base temperature where the slope doubles
COLD_KNEE, 30, °C below base temperature where the slope halves

Ports:
i_clk_50m  in  1  system clock
i_rst_n  in  1  reset, synchronous, active-low
i_temp_valid  in  1  one-cycle strobe; i_temp_value is valid
i_temp_value  in  TEMP_W  signed device temperature
i_temp_base  in  TEMP_W  signed compensation base temperature
i_temp_coe  in  COE_W  base slope coefficient
i_hv_base  in  HV_W  HV code at base temperature
i_max_step  in  HV_W  max HV change per update; 0 = unlimited
i_comp_en  in  1  0 = bypass (target = i_hv_base)
o_busy  out  1  update in progress
o_dac_start  out  1  one-cycle DAC write strobe
o_dac_value  out  DAC_W  DAC code
o_hv_code  out  HV_W  current HV code
o_zone  out  2  00 linear, 01 hot, 10 cold (last update)
o_clamped  out  1  last target hit HV_MIN/HV_MAX

Behaviour:
- Reset (synchronous, i_rst_n=0 at a clock edge): state IDLE; o_busy=0, o_dac_start=0, o_hv_code=HV_MIN, o_dac_value=HV_MIN>>(HV_W-DAC_W), o_zone=0, o_clamped=0, primed=0. Reset mid-update aborts it with no strobe.
- States: IDLE -> CAPTURE -> MUL1 (TEMP_W+1 cycles) -> MUL2 (TEMP_W+1 cycles) -> SUM -> CLAMP -> SLEW -> OUT -> IDLE.
- IDLE: i_temp_valid=1 -> CAPTURE. In CAPTURE, all i_* config inputs and the temperature are registered; later input changes do not affect this update.
- i_temp_valid while o_busy=1 is ignored; no queueing. o_busy is 1 from CAPTURE through SLEW and 0 in OUT.
- Fixed latency: valid sampled at edge 0 -> o_dac_start=1 for exactly one cycle at edge 2*TEMP_W+7 (23 at default). o_hv_code, o_dac_value, o_zone and o_clamped update in the same cycle. A new valid is accepted on the cycle after the strobe.
- Arithmetic: delta = temp - base, signed with TEMP_W+1 bits; mag = |delta|; knee = HOT_KNEE if delta≥0, else COLD_KNEE.
  - p1 = coe * min(mag, knee).
  - p2 = scoe * max(mag-knee, 0), where scoe = coe<<1 if delta≥0, else coe>>1 (floor).
  - corr = p1+p2, computed at full width with no truncation. target = hv_base ± corr (+ if delta≥0).
- Zone: hot if delta ≥ HOT_KNEE, cold if delta ≤ -COLD_KNEE, else linear.
- MUL2 always runs, even when p2=0, so latency stays constant.
- i_comp_en=0: corr forced to 0, zone=00; latency unchanged.
- CLAMP: compute in signed width max(HV_W, COE_W+TEMP_W+3)+2. target<HV_MIN -> HV_MIN; target>HV_MAX -> HV_MAX; o_clamped set accordingly.
- SLEW: if primed=1, i_max_step≠0 and |target - o_hv_code| > i_max_step, new = o_hv_code ± i_max_step; otherwise new = target. primed is set after the first OUT.

Decomposition:
- Package apd_hv_pkg: state encoding (one-hot, 8 states), zone codes, and a localparam function for the internal width.
- Sub-module seq_mult_u: unsigned shift-add multiplier, start/done handshake, A=COE_W+1 bits, B=TEMP_W+1 bits, one multiplier bit per cycle, done exactly TEMP_W+1 cycles after start. The top level runs it twice per update.

Test Plan:
1. base=25, coe=10, hv_base=2000, temp=35 -> o_hv_code=2100, o_dac_value=525, zone 00, strobe at cycle 23.
2. Same config, temp=55 -> corr 10*20+20*10=400 -> 2400, dac 600, zone 01.
3. Same config, temp=-15 -> corr 10*30+5*10=350 -> 1650, dac 412, zone 10.
4. hv_base=3900, temp=55 -> 4000, o_clamped=1, dac 1000; hv_base=1200, temp=-15 -> 1150, o_clamped=1, dac 287.
5. After test 1 (primed, 2100), max_step=50, temp=55 -> 2150; repeat -> 2200; i_comp_en=0 with hv_base=2000 and max_step=0 -> 2000.
6. Valid pulsed at cycles 0 and 5 -> exactly one strobe, at cycle 23. Reset asserted at cycle 6 -> no strobe, o_hv_code=1150; the next update to target 2100 with max_step=50 is unslewed (2100).
